// File: rtl/spi_master.sv
// Register-mapped SPI master: 8-bit frames, programmable CPOL/CPHA/bit order/SCK divider,
// 8-deep TX/RX FIFOs, software chip-selects and a maskable level interrupt.
module spi_master #(
    parameter int cs_w = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [4:0]      addr,
    input  logic            re,
    input  logic            we,
    input  logic [31:0]     wd,
    output logic [31:0]     rd,
    output logic            irq,
    output logic            spi_mosi,
    input  logic            spi_miso,
    output logic            spi_sck,
    output logic [cs_w-1:0] spi_cs
);

    localparam logic [2:0] REG_CR    = 3'd0;
    localparam logic [2:0] REG_SR    = 3'd1;
    localparam logic [2:0] REG_DR    = 3'd2;
    localparam logic [2:0] REG_DFR   = 3'd3;
    localparam logic [2:0] REG_CS    = 3'd4;
    localparam logic [2:0] REG_IRQ_M = 3'd5;
    localparam logic [2:0] REG_IRQ_V = 3'd6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [2:0]      sel;
    logic            wr_cr, wr_dr, wr_dfr, wr_cs, wr_irq_m, wr_irq_v, rd_dr;
    logic [6:0]      cr;
    logic [15:0]     dfr;
    logic [cs_w-1:0] cs_v;
    logic [2:0]      irq_m, irq_v, irq_set;
    logic            unused_bits;

    assign sel      = addr[4:2];
    assign wr_cr    = we && (sel == REG_CR);
    assign wr_dr    = we && (sel == REG_DR);
    assign wr_dfr   = we && (sel == REG_DFR);
    assign wr_cs    = we && (sel == REG_CS);
    assign wr_irq_m = we && (sel == REG_IRQ_M);
    assign wr_irq_v = we && (sel == REG_IRQ_V);
    assign rd_dr    = re && (sel == REG_DR);
    assign unused_bits = ^{addr[1:0], wd[31:16]};

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cr    <= '0;
            dfr   <= '0;
            cs_v  <= '1;
            irq_m <= '0;
        end else begin
            if (wr_cr)    cr    <= wd[6:0];
            if (wr_dfr)   dfr   <= wd[15:0];
            if (wr_cs)    cs_v  <= wd[cs_w-1:0];
            if (wr_irq_m) irq_m <= wd[2:0];
        end
    end

    assign spi_cs = cs_v;

    // ---------------- FIFOs ----------------
    logic [7:0] tx_mem [8];
    logic [7:0] rx_mem [8];
    logic [2:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [3:0] tx_cnt, rx_cnt;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic       tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0] tx_head, rx_din;

    assign tx_full  = (tx_cnt == 4'd8);
    assign tx_empty = (tx_cnt == 4'd0);
    assign rx_full  = (rx_cnt == 4'd8);
    assign rx_empty = (rx_cnt == 4'd0);
    assign tx_push  = wr_dr && !tx_full;
    assign rx_pop   = rd_dr && !rx_empty;
    assign tx_head  = tx_mem[tx_rp];

    // NOTE: FIFO storage has no reset; the pointers and counts alone define what is valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= wd[7:0];
        if (rx_push) rx_mem[rx_wp] <= rx_din;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 3'd1;
            if (tx_pop)  tx_rp <= tx_rp + 3'd1;
            if (rx_push) rx_wp <= rx_wp + 3'd1;
            if (rx_pop)  rx_rp <= rx_rp + 3'd1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 4'd1;
                2'b01:   tx_cnt <= tx_cnt - 4'd1;
                default: tx_cnt <= tx_cnt;
            endcase
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 4'd1;
                2'b01:   rx_cnt <= rx_cnt - 4'd1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // ---------------- Transfer engine ----------------
    logic [1:0]  state;
    logic [15:0] div_cnt;
    logic [3:0]  edge_cnt;
    logic [7:0]  tx_sh, rx_sh, rx_next;
    logic        cpha_q, lsb_q;
    logic        tick, sample_now, shift_now, last_edge, can_start, busy;

    function automatic logic [7:0] shift_out(input logic [7:0] v, input logic lsb);
        return lsb ? {1'b0, v[7:1]} : {v[6:0], 1'b0};
    endfunction

    assign busy       = (state != ST_IDLE);
    assign can_start  = !tx_empty && !rx_full;
    assign tick       = (div_cnt >= dfr);
    // Even edge counts are leading edges; cpha selects which edge type samples MISO.
    assign sample_now = (state == ST_SHIFT) && tick && (~edge_cnt[0] ^ cpha_q);
    assign shift_now  = (state == ST_SHIFT) && tick && !(~edge_cnt[0] ^ cpha_q) && (edge_cnt != 4'd15);
    assign last_edge  = (state == ST_SHIFT) && tick && (edge_cnt == 4'd15);
    assign rx_next    = lsb_q ? {spi_miso, rx_sh[7:1]} : {rx_sh[6:0], spi_miso};
    assign rx_din     = sample_now ? rx_next : rx_sh;
    assign rx_push    = last_edge && !rx_full;
    assign tx_pop     = (state == ST_LOAD);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    spi_sck <= cr[0];
                    if (can_start) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    cpha_q   <= cr[1];
                    lsb_q    <= cr[2];
                    spi_sck  <= cr[0];
                    div_cnt  <= '0;
                    edge_cnt <= '0;
                    rx_sh    <= '0;
                    // cpha=0 needs the first bit on MOSI before the first SCK edge.
                    if (!cr[1]) begin
                        spi_mosi <= cr[2] ? tx_head[0] : tx_head[7];
                        tx_sh    <= shift_out(tx_head, cr[2]);
                    end else begin
                        tx_sh    <= tx_head;
                    end
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (tick) begin
                        div_cnt  <= '0;
                        spi_sck  <= ~spi_sck;
                        edge_cnt <= edge_cnt + 4'd1;
                        if (sample_now) rx_sh <= rx_next;
                        if (shift_now) begin
                            spi_mosi <= lsb_q ? tx_sh[0] : tx_sh[7];
                            tx_sh    <= shift_out(tx_sh, lsb_q);
                        end
                        if (last_edge) state <= ST_GAP;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                default: begin
                    if (tick) begin
                        div_cnt <= '0;
                        state   <= can_start ? ST_LOAD : ST_IDLE;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    // ---------------- Interrupts ----------------
    logic [3:0] tx_thr, rx_thr;

    assign tx_thr  = 4'd1 << cr[4:3];
    assign rx_thr  = 4'd1 << cr[6:5];
    assign irq_set = {last_edge, (tx_cnt < tx_thr), (rx_cnt >= rx_thr)};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            irq_v <= '0;
            irq   <= 1'b0;
        end else begin
            irq_v <= (wr_irq_v ? wd[2:0] : irq_v) | irq_set;
            irq   <= |(irq_v & irq_m);
        end
    end

    // ---------------- Read path ----------------
    logic [31:0] rd_mux;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rd_mux = '0;
        case (sel)
            REG_CR:    rd_mux = {25'b0, cr};
            REG_SR:    rd_mux = {27'b0, busy, rx_empty, rx_full, tx_empty, tx_full};
            REG_DR:    rd_mux = rx_empty ? 32'h0 : {24'b0, rx_mem[rx_rp]};
            REG_DFR:   rd_mux = {16'b0, dfr};
            REG_CS:    rd_mux = 32'(cs_v);
            REG_IRQ_M: rd_mux = {29'b0, irq_m};
            REG_IRQ_V: rd_mux = {29'b0, irq_v};
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn)   rd <= '0;
        else if (re) rd <= rd_mux;
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master: reset, loopback, SPI modes,
// FIFO overflow/stall, interrupt clearing and mid-frame reset.
module tb_spi_master;

    localparam logic [4:0] A_CR  = 5'h00;
    localparam logic [4:0] A_SR  = 5'h04;
    localparam logic [4:0] A_DR  = 5'h08;
    localparam logic [4:0] A_DFR = 5'h0C;
    localparam logic [4:0] A_CS  = 5'h10;
    localparam logic [4:0] A_IM  = 5'h14;
    localparam logic [4:0] A_IV  = 5'h18;
    localparam logic [4:0] A_NA  = 5'h1C;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [4:0]  addr = '0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic        irq, spi_mosi, spi_sck, spi_miso;
    logic [7:0]  spi_cs;
    logic        loop_en = 1'b0;
    logic        miso_drv = 1'b0;

    int checks = 0;
    int failures = 0;

    assign spi_miso = loop_en ? spi_mosi : miso_drv;

    spi_master #(.cs_w(8)) dut (
        .clk(clk), .rstn(rstn), .addr(addr), .re(re), .we(we), .wd(wd), .rd(rd),
        .irq(irq), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_sck(spi_sck), .spi_cs(spi_cs)
    );

    always #5 clk = ~clk;

    // Cycle counter and SCK period monitor (periods in clk cycles between rising edges).
    int unsigned cyc = 0;
    int unsigned last_rise = 0;
    int unsigned last_per = 0;
    int unsigned min_per = 32'hFFFF_FFFF;
    logic        sck_q = 1'b0;
    logic        have_rise = 1'b0;
    logic        meas_en = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        sck_q <= spi_sck;
        if (!meas_en) begin
            have_rise <= 1'b0;
            min_per   <= 32'hFFFF_FFFF;
        end else if (spi_sck && !sck_q) begin
            if (have_rise) begin
                last_per <= cyc - last_rise;
                if (cyc - last_rise < min_per) min_per <= cyc - last_rise;
            end
            have_rise <= 1'b1;
            last_rise <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bus tasks are entered on a falling edge and return on the next falling edge.
    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        addr = a; wd = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        addr = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        d = rd;
    endtask

    task automatic wait_sr(input string tag, input logic [31:0] mask, input logic [31:0] val,
                           input int budget);
        logic [31:0] s;
        int n;
        n = 0;
        do begin
            bus_read(A_SR, s);
            n++;
        end while (((s & mask) != val) && (n < budget));
        check(tag, s & mask, val);
    endtask

    string       msg = "Hello World!\n";
    logic [7:0]  rx_buf [16];
    logic [31:0] d;
    int          sent, got;
    int unsigned t0;

    // Mode table: cfg = {lsb, cpha, cpol}; slave always shifts 0xC5 out first-bit-first.
    logic [2:0] m_cfg [6] = '{3'b000, 3'b010, 3'b001, 3'b011, 3'b100, 3'b111};
    logic [7:0] m_tx  [6] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h1E};
    logic [7:0] m_seq [6] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h78};
    logic [7:0] m_rx  [6] = '{8'hC5, 8'hC5, 8'hC5, 8'hC5, 8'hA3, 8'hA3};
    logic [7:0] mseq, seq;
    logic       prev, cpol, cpha;
    int         nb, guard;

    initial begin
        // ---- reset ----
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_sck", {31'b0, spi_sck}, 32'h0);
        check("rst_cs", {24'b0, spi_cs}, 32'hFF);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_rd", rd, 32'h0);
        bus_read(A_SR, d);
        check("rst_sr", d, 32'h0A);

        // ---- register access ----
        bus_write(A_CR, 32'hFFFF_FF7F);
        bus_read(A_CR, d);
        check("cr_rw", d, 32'h7F);
        bus_write(A_NA, 32'hDEAD_BEEF);
        bus_read(A_NA, d);
        check("unmapped_rd", d, 32'h0);
        bus_write(A_CR, 32'h0);

        // ---- loopback "Hello World!\n" ----
        loop_en = 1'b1;
        bus_write(A_CR, 32'h28);
        bus_write(A_DFR, 32'd200);
        bus_write(A_CS, 32'h55);
        bus_write(A_IV, 32'h0);
        bus_write(A_IM, 32'h1);
        meas_en = 1'b1;
        sent = 0;
        got = 0;
        t0 = cyc;
        while (got < 12 && (cyc - t0) < 60000) begin
            if (irq) begin
                bus_read(A_DR, d); rx_buf[got] = d[7:0]; got++;
                bus_read(A_DR, d); rx_buf[got] = d[7:0]; got++;
                bus_write(A_IV, 32'h0);
                @(negedge clk);
            end else if (sent < 13) begin
                bus_read(A_SR, d);
                if (!d[0]) begin
                    bus_write(A_DR, {24'b0, msg[sent]});
                    sent++;
                end
            end else begin
                @(negedge clk);
            end
        end
        check("lb_irq_bytes", got, 12);
        wait_sr("lb_final_idle", 32'h1A, 32'h02, 10000);
        bus_read(A_DR, d);
        rx_buf[12] = d[7:0];
        for (int i = 0; i < 13; i++)
            check($sformatf("lb_byte%0d", i), {24'b0, rx_buf[i]}, {24'b0, msg[i]});
        check("lb_cs", {24'b0, spi_cs}, 32'h55);
        check("lb_min_bit_cycles", min_per, 402);
        check("lb_last_bit_cycles", last_per, 402);
        meas_en = 1'b0;
        bus_write(A_IM, 32'h0);
        loop_en = 1'b0;

        // ---- SPI modes ----
        bus_write(A_DFR, 32'd1);
        for (int m = 0; m < 6; m++) begin
            cpol = m_cfg[m][0];
            cpha = m_cfg[m][1];
            mseq = m_rx[m] == 8'hA3 ? 8'hC5 : 8'hC5;
            bus_write(A_CR, {29'b0, m_cfg[m]});
            @(negedge clk);
            check($sformatf("mode%0d_idle_sck", m), {31'b0, spi_sck}, {31'b0, cpol});
            miso_drv = mseq[7];
            bus_write(A_DR, {24'b0, m_tx[m]});
            prev = spi_sck;
            nb = 0;
            seq = '0;
            guard = 0;
            while (nb < 8 && guard < 200) begin
                @(negedge clk);
                guard++;
                if (spi_sck !== prev) begin
                    prev = spi_sck;
                    if ((spi_sck != cpol) ^ cpha) begin
                        seq = {seq[6:0], spi_mosi};
                        nb++;
                        if (nb < 8) miso_drv = mseq[7 - nb];
                    end
                end
            end
            check($sformatf("mode%0d_sample_edges", m), nb, 8);
            wait_sr($sformatf("mode%0d_done", m), 32'h18, 32'h00, 200);
            check($sformatf("mode%0d_mosi_seq", m), {24'b0, seq}, {24'b0, m_seq[m]});
            check($sformatf("mode%0d_end_sck", m), {31'b0, spi_sck}, {31'b0, cpol});
            bus_read(A_DR, d);
            check($sformatf("mode%0d_rx", m), d, {24'b0, m_rx[m]});
        end

        // ---- TX overflow and RX-full stall ----
        loop_en = 1'b1;
        bus_write(A_CR, 32'h0);
        bus_write(A_DFR, 32'hFFFF);
        for (int i = 0; i < 9; i++) bus_write(A_DR, 32'h10 + i);
        bus_read(A_SR, d);
        check("ovf_full_after_9", d & 32'h13, 32'h11);
        bus_write(A_DR, 32'h19);
        bus_read(A_SR, d);
        check("ovf_full_after_10", d & 32'h03, 32'h01);
        bus_write(A_DFR, 32'h0);
        wait_sr("ovf_rx_full", 32'h14, 32'h04, 2000);
        repeat (50) @(negedge clk);
        bus_read(A_SR, d);
        check("ovf_stall_sr", d, 32'h04);
        for (int i = 0; i < 8; i++) begin
            bus_read(A_DR, d);
            check($sformatf("ovf_rx%0d", i), d, 32'h10 + i);
        end
        wait_sr("ovf_frame9", 32'h1A, 32'h02, 500);
        bus_read(A_DR, d);
        check("ovf_rx8", d, 32'h18);
        repeat (50) @(negedge clk);
        bus_read(A_SR, d);
        check("ovf_only_9_frames", d, 32'h0A);
        bus_read(A_DR, d);
        check("dr_empty_read", d, 32'h0);

        // ---- IRQ clear with level still true ----
        bus_write(A_DFR, 32'd1);
        bus_write(A_IV, 32'h0);
        bus_write(A_IM, 32'h1);
        bus_write(A_DR, 32'h5A);
        wait_sr("irq_frame", 32'h18, 32'h00, 200);
        @(negedge clk);
        check("irq_set", {31'b0, irq}, 32'h1);
        bus_write(A_IV, 32'h0);
        bus_read(A_IV, d);
        check("irq_v_resets", d, 32'h3);
        check("irq_still_high", {31'b0, irq}, 32'h1);
        bus_read(A_DR, d);
        check("irq_drain", d, 32'h5A);
        bus_write(A_IV, 32'h0);
        check("irq_lag_cycle", {31'b0, irq}, 32'h1);
        @(negedge clk);
        check("irq_cleared", {31'b0, irq}, 32'h0);
        bus_read(A_IV, d);
        check("irq_v_after_drain", d, 32'h2);

        // ---- reset mid-frame ----
        bus_write(A_CR, 32'h1);
        bus_write(A_DFR, 32'd50);
        bus_write(A_IM, 32'h7);
        bus_write(A_DR, 32'h77);
        bus_write(A_DR, 32'h78);
        repeat (300) @(negedge clk);
        bus_read(A_SR, d);
        check("mid_busy", d & 32'h10, 32'h10);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("mid_rst_sck", {31'b0, spi_sck}, 32'h0);
        check("mid_rst_mosi", {31'b0, spi_mosi}, 32'h0);
        check("mid_rst_cs", {24'b0, spi_cs}, 32'hFF);
        check("mid_rst_irq", {31'b0, irq}, 32'h0);
        check("mid_rst_rd", rd, 32'h0);
        repeat (20) @(negedge clk);
        bus_read(A_SR, d);
        check("mid_rst_sr", d, 32'h0A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
